// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the SPI/CPU memory arbiter.
// The grant type records which access owned the RAM port in the previous cycle.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SPI    = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } grant_type_t;

    localparam logic [15:0] ROM_BASE_DEFAULT = 16'hE000;

endpackage

// File: rtl/spi_cpu_mem_arbiter.sv
// Shares one synchronous SRAM port between the SPI slave (never stalled) and the 6502 bus.
// Read data is steered per requester using the grant type registered in the previous cycle.
module spi_cpu_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int              MEM_AW   = 17,
    parameter logic [MEM_AW-17:0] CPU_BANK = 'h1,
    parameter logic [15:0]     ROM_BASE = ROM_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_en,
    input  logic              spi_wr,
    input  logic [23:0]       spi_addr,
    input  logic [7:0]        spi_wdata,
    output logic [7:0]        spi_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_do,
    output logic [7:0]        cpu_di,
    output logic              cpu_rdy,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        stat_stall
);

    grant_type_t last_grant;
    grant_type_t grant_d;
    logic        stall_q;
    logic        stall_d;
    logic        rom_hit;
    logic [7:0]  cpu_di_q;
    logic        unused_spi_hi;

    assign unused_spi_hi = ^spi_addr[23:MEM_AW];
    assign rom_hit       = (cpu_addr >= ROM_BASE);
    assign stall_d       = cpu_req && spi_en;

    // SPI writes need no read-data steering, so they are recorded as NONE.
    always_comb begin
        grant_d   = NONE;
        ram_en    = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst) begin
            grant_d = NONE;
        end else if (spi_en) begin
            ram_en    = 1'b1;
            ram_wr    = spi_wr;
            ram_addr  = spi_addr[MEM_AW-1:0];
            ram_wdata = spi_wdata;
            grant_d   = spi_wr ? NONE : SPI;
        end else if (cpu_req) begin
            ram_addr  = {CPU_BANK, cpu_addr};
            ram_wdata = cpu_do;
            if (cpu_we) begin
                grant_d = CPU_WR;
                ram_en  = !rom_hit;
                ram_wr  = !rom_hit;
            end else begin
                grant_d = CPU_RD;
                ram_en  = 1'b1;
            end
        end
    end

    assign cpu_rdy = !stall_q;
    assign cpu_di  = (last_grant == CPU_RD) ? ram_rdata : cpu_di_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= NONE;
            stall_q    <= 1'b0;
            spi_rdata  <= 8'h00;
            cpu_di_q   <= 8'h00;
            stat_stall <= 8'h00;
        end else begin
            last_grant <= grant_d;
            stall_q    <= stall_d;
            if (stall_d && (stat_stall != 8'hFF))
                stat_stall <= stat_stall + 8'd1;
            if (last_grant == CPU_RD)
                cpu_di_q <= ram_rdata;
            if (last_grant == SPI)
                spi_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_spi_cpu_mem_arbiter.sv
// Directed bench for spi_cpu_mem_arbiter with a behavioural 1-cycle-latency SRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_spi_cpu_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        spi_en;
    logic        spi_wr;
    logic [23:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic [7:0]  spi_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        ram_en;
    logic        ram_wr;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  stat_stall;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:(1<<17)-1];

    spi_cpu_mem_arbiter #(
        .MEM_AW   (17),
        .CPU_BANK (1'b1),
        .ROM_BASE (16'hE000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_en     (spi_en),
        .spi_wr     (spi_wr),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_rdata  (spi_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_do     (cpu_do),
        .cpu_di     (cpu_di),
        .cpu_rdy    (cpu_rdy),
        .ram_en     (ram_en),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .stat_stall (stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr)
                mem[ram_addr] <= ram_wdata;
            else
                ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        spi_en  = 1'b0;
        spi_wr  = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic spi_write(input logic [23:0] a, input logic [7:0] d);
        spi_en    = 1'b1;
        spi_wr    = 1'b1;
        spi_addr  = a;
        spi_wdata = d;
        step();
        idle_in();
    endtask

    task automatic cpu_read_req(input logic [15:0] a);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
    endtask

    initial begin
        idle_in();
        rst       = 1'b1;
        spi_addr  = '0;
        spi_wdata = '0;
        cpu_addr  = '0;
        cpu_do    = '0;
        ram_rdata = '0;
        step();
        step();
        rst = 1'b0;

        @(negedge clk);
        check("rst_cpu_rdy", cpu_rdy, 1);
        check("rst_ram_en", ram_en, 0);
        check("rst_spi_rdata", spi_rdata, 8'h00);
        check("rst_cpu_di", cpu_di, 8'h00);
        check("rst_stat", stat_stall, 8'h00);
        step();

        spi_write(24'h011234, 8'hA5);
        spi_write(24'h001234, 8'h11);
        spi_write(24'h012000, 8'h22);
        spi_write(24'h00FF00, 8'h3C);
        spi_write(24'h01E005, 8'h00);
        for (int i = 0; i < 20; i++)
            spi_write(24'h013000 + 24'(i), 8'(i));
        @(negedge clk);
        check("spi_wr_no_rdata", spi_rdata, 8'h00);
        step();

        // plain CPU read
        cpu_read_req(16'h1234);
        @(negedge clk);
        check("rd_ram_en", ram_en, 1);
        check("rd_ram_wr", ram_wr, 0);
        check("rd_ram_addr", ram_addr, 17'h11234);
        check("rd_cpu_rdy", cpu_rdy, 1);
        step();
        idle_in();
        @(negedge clk);
        check("rd_cpu_di", cpu_di, 8'hA5);
        check("rd_rdy_after", cpu_rdy, 1);
        step();
        @(negedge clk);
        check("rd_cpu_di_hold", cpu_di, 8'hA5);
        step();

        // SPI read colliding with CPU read
        spi_en   = 1'b1;
        spi_wr   = 1'b0;
        spi_addr = 24'h001234;
        cpu_read_req(16'h2000);
        @(negedge clk);
        check("col_spi_addr", ram_addr, 17'h01234);
        check("col_spi_rd", ram_wr, 0);
        step();
        spi_en = 1'b0;
        @(negedge clk);
        check("col_rdy_low", cpu_rdy, 0);
        check("col_cpu_addr", ram_addr, 17'h12000);
        check("col_cpu_en", ram_en, 1);
        check("col_stat", stat_stall, 8'd1);
        step();
        idle_in();
        @(negedge clk);
        check("col_rdy_back", cpu_rdy, 1);
        check("col_cpu_di", cpu_di, 8'h22);
        check("col_spi_rdata", spi_rdata, 8'h11);
        step();

        // SPI read data holds across CPU traffic
        spi_en   = 1'b1;
        spi_wr   = 1'b0;
        spi_addr = 24'h00FF00;
        step();
        idle_in();
        for (int i = 0; i < 20; i++) begin
            cpu_read_req(16'h3000 + 16'(i));
            step();
        end
        idle_in();
        @(negedge clk);
        check("hold_spi_rdata", spi_rdata, 8'h3C);
        check("hold_cpu_di", cpu_di, 8'h13);
        step();

        // write protect and its boundary
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 16'hE005;
        cpu_do   = 8'h99;
        @(negedge clk);
        check("rom_ram_en", ram_en, 0);
        check("rom_rdy", cpu_rdy, 1);
        step();
        cpu_addr = 16'hDFFF;
        cpu_do   = 8'h66;
        @(negedge clk);
        check("below_rom_en", ram_en, 1);
        check("below_rom_wr", ram_wr, 1);
        check("below_rom_addr", ram_addr, 17'h1DFFF);
        check("below_rom_wdata", ram_wdata, 8'h66);
        step();
        cpu_read_req(16'hE005);
        step();
        idle_in();
        @(negedge clk);
        check("rom_unchanged", cpu_di, 8'h00);
        step();
        spi_write(24'h01E005, 8'h77);
        cpu_read_req(16'hE005);
        step();
        idle_in();
        @(negedge clk);
        check("rom_spi_written", cpu_di, 8'h77);
        step();

        // SPI write colliding with CPU read of the same byte
        spi_en    = 1'b1;
        spi_wr    = 1'b1;
        spi_addr  = 24'h011000;
        spi_wdata = 8'h5A;
        cpu_read_req(16'h1000);
        @(negedge clk);
        check("wcol_ram_wr", ram_wr, 1);
        check("wcol_ram_addr", ram_addr, 17'h11000);
        check("wcol_wdata", ram_wdata, 8'h5A);
        step();
        spi_en = 1'b0;
        spi_wr = 1'b0;
        @(negedge clk);
        check("wcol_rdy_low", cpu_rdy, 0);
        check("wcol_cpu_rd", ram_wr, 0);
        step();
        idle_in();
        @(negedge clk);
        check("wcol_cpu_di", cpu_di, 8'h5A);
        check("wcol_rdy_back", cpu_rdy, 1);
        check("wcol_stat", stat_stall, 8'd2);
        step();

        // back-to-back collisions until saturation
        spi_en   = 1'b1;
        spi_wr   = 1'b0;
        spi_addr = 24'h000000;
        cpu_read_req(16'h0000);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 1)
                check("sat_rdy_low", cpu_rdy, 0);
            if (i == 1)
                check("sat_spi_owns", ram_addr, 17'h00000);
            if (i == 100)
                check("sat_stat_mid", stat_stall, 8'd102);
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        check("sat_stat_ff", stat_stall, 8'hFF);
        check("sat_rdy_low_end", cpu_rdy, 0);
        step();
        rst = 1'b0;
        idle_in();
        @(negedge clk);
        check("mid_rst_rdy", cpu_rdy, 1);
        check("mid_rst_stat", stat_stall, 8'h00);
        check("mid_rst_spi_rdata", spi_rdata, 8'h00);
        check("mid_rst_cpu_di", cpu_di, 8'h00);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
